// File: rtl/stream_to_sub_array_loader.sv
// Streams LANES elements per beat into a ROWS x COLS frame in sub-array order, then holds it for a consumer.
// Optional `SUB_ARRAY_LOADER_FLUSH_EN adds a flush input that aborts the current frame.

module stream_to_sub_array_cell #(
  parameter int BIT_WIDTH = 4,
  parameter int CW        = 5,
  parameter int BEAT      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic [CW-1:0]        beat_cnt,
  input  logic [BIT_WIDTH-1:0] din,
  output logic [BIT_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)                                     q <= '0;
    else if (accept && beat_cnt == CW'(BEAT))    q <= din;
  end
endmodule

module stream_to_sub_array_loader #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4,
  parameter int LANES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*BIT_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BIT_WIDTH-1:0]       out [ROWS][COLS],
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
  ,input  logic                      flush
`endif
);
  localparam int BEATS = ROWS*COLS/LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int R2    = ROWS - SUB_ROWS;

  typedef enum logic {FILL, HOLD} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic          accept, flush_i;

`ifdef SUB_ARRAY_LOADER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign in_ready  = (state == FILL) && !flush_i;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    if (flush_i) begin
      state_nx    = FILL;
      beat_cnt_nx = '0;
    end else begin
      case (state)
        FILL: if (accept) begin
          if (beat_cnt == CW'(BEATS-1)) begin
            state_nx    = HOLD;
            beat_cnt_nx = '0;
          end else begin
            beat_cnt_nx = beat_cnt + 1'b1;
          end
        end
        HOLD: if (out_ready) state_nx = FILL;
        default: state_nx = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  // Each element register has a fixed stream index k, hence a fixed (beat, lane) source.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K    = (r < SUB_ROWS) ? (c*SUB_ROWS + r)
                                           : (COLS*SUB_ROWS + c*R2 + (r - SUB_ROWS));
      localparam int BEAT = K / LANES;
      localparam int LANE = K % LANES;
      stream_to_sub_array_cell #(.BIT_WIDTH(BIT_WIDTH), .CW(CW), .BEAT(BEAT)) u_cell (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .beat_cnt (beat_cnt),
        .din      (in_data[LANE*BIT_WIDTH +: BIT_WIDTH]),
        .q        (out[r][c])
      );
    end
  end
endmodule

// File: tb/tb_stream_to_sub_array_loader.sv
// Random-stimulus bench: two loaders (SUB_ROWS=4 and SUB_ROWS=ROWS) fed the same stream, checked against a frame model.
module tb_stream_to_sub_array_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, out_ready;
  logic       in_ready_a, in_ready_b, ov_a, ov_b;
  logic [3:0] out_a [8][8];
  logic [3:0] out_b [8][8];
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
  logic       flush = 1'b0;
`endif

  logic [3:0] exp_m [2][8][8];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  stream_to_sub_array_loader #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(4), .LANES(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out(out_a), .out_valid(ov_a), .out_ready(out_ready)
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    , .flush(flush)
`endif
  );

  stream_to_sub_array_loader #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(8), .LANES(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out(out_b), .out_valid(ov_b), .out_ready(out_ready)
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    , .flush(flush)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Place element k of the stream at its (row, col) from the sub-array ordering rule.
  task automatic model_put(input int k, input logic [3:0] v);
    for (int d = 0; d < 2; d++) begin
      int sr, row, col;
      sr = (d == 0) ? 4 : 8;
      if (k < 8*sr) begin
        col = k / sr; row = k % sr;
      end else begin
        col = (k - 8*sr) / (8 - sr); row = sr + (k - 8*sr) % (8 - sr);
      end
      exp_m[d][row][col] = v;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) exp_m[d][r][c] = 4'h0;
  endtask

  function automatic int mism(input logic [3:0] o [8][8], input int d);
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (o[r][c] !== exp_m[d][r][c]) n++;
    return n;
  endfunction

  // mode 0: k%16 solid, 1: k%16 toggling valid, 2: random data/gaps, 3: all 0xA
  task automatic frame(input int mode, input int nbeats, input bit rdy_in_fill);
    logic [3:0] vals [64];
    int b = 0;
    int cyc = 0;
    bit v;
    for (int k = 0; k < 64; k++)
      vals[k] = (mode == 3) ? 4'hA : (mode == 2) ? 4'($urandom) : 4'(k % 16);
    out_ready = rdy_in_fill;
    while (b < nbeats) begin
      @(negedge clk);
      if (cyc > 400) begin
        chk("frame_timeout", b, nbeats);
        break;
      end
      v = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_data  = {vals[2*b+1], vals[2*b]};
      if (v && in_ready_a) begin
        if (b == 31) chk("ov_before_last", ov_a, 0);
        model_put(2*b, vals[2*b]);
        model_put(2*b+1, vals[2*b+1]);
        b++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (nbeats == 32) begin
      chk("ov_a_rise", ov_a, 1);
      chk("ov_b_rise", ov_b, 1);
      chk("in_ready_hold", in_ready_a, 0);
      chk("frame_a", mism(out_a, 0), 0);
      chk("frame_b", mism(out_b, 1), 0);
    end
  endtask

  task automatic consume(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ov", ov_a, 1);
      chk("hold_in_ready", in_ready_a, 0);
      chk("hold_frame", mism(out_a, 0) + mism(out_b, 1), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready_a, 1);
    chk("post_hs_ov", ov_a | ov_b, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_ov", ov_a | ov_b, 0);
    chk("rst_frame", mism(out_a, 0) + mism(out_b, 1), 0);
    rst = 1'b0;

    frame(0, 32, 1'b0);
    chk("a_0_0", out_a[0][0], 0);
    chk("a_3_0", out_a[3][0], 3);
    chk("a_0_1", out_a[0][1], 4);
    chk("a_4_0", out_a[4][0], 0);
    chk("a_5_0", out_a[5][0], 1);
    chk("a_7_7", out_a[7][7], 15);
    chk("b_1_0", out_b[1][0], 1);
    chk("b_0_1", out_b[0][1], 8);
    chk("b_7_7", out_b[7][7], 15);
    consume(10);

    frame(1, 32, 1'b0);
    consume(2);
    frame(3, 32, 1'b0);
    chk("all_a_count", 64 - mism(out_a, 0), 64);
    consume(0);

    for (int i = 0; i < 3; i++) begin
      frame(2, 32, i == 1);
      if (i == 1) begin
        @(negedge clk);
        out_ready = 1'b0;
        chk("auto_hs_in_ready", in_ready_a, 1);
        chk("auto_hs_ov", ov_a, 0);
      end else begin
        consume($urandom_range(0, 5));
      end
    end

    frame(2, 12, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    chk("midrst_ov", ov_a | ov_b, 0);
    chk("midrst_frame", mism(out_a, 0) + mism(out_b, 1), 0);
    rst = 1'b0;
    frame(2, 32, 1'b0);
    consume(1);

`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    frame(2, 20, 1'b0);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_blocks", in_ready_a, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_ov", ov_a, 0);
    frame(2, 32, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_hold_ov", ov_a, 0);
    chk("flush_hold_in_ready", in_ready_a, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_to_sub_array_loader.md
# stream_to_sub_array_loader

Sequential successor to the combinational flat-bus-to-array converters. Accepts a stream of `LANES` elements per beat under a valid/ready handshake and assembles one `ROWS` x `COLS` frame in sub-array order: the top `SUB_ROWS` rows column-major, then the remaining rows column-major. It then presents the frame as a 2-D output array with its own valid/ready handshake. It sits between a narrow memory/DMA stream and array-consuming compute blocks.

## Interface
Parameters:
- `BIT_WIDTH`, 4, element width in bits.
- `ROWS`, 8, frame rows.
- `COLS`, 8, frame columns.
- `SUB_ROWS`, 4, rows in the upper sub-array; 1 <= `SUB_ROWS` <= `ROWS`.
- `LANES`, 2, elements per input beat; `ROWS*COLS` is a multiple of `LANES`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `LANES*BIT_WIDTH`  lane `l` occupies bits `[(l+1)*BIT_WIDTH-1 : l*BIT_WIDTH]`.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `out`  out  `[BIT_WIDTH-1:0] [ROWS][COLS]`  assembled frame.
- `out_valid`  out  1  frame complete and stable.
- `out_ready`  in  1  consumer takes frame when `out_valid && out_ready`.
- `flush`  in  1  present only with `SUB_ARRAY_LOADER_FLUSH_EN`.

## Operation
- Definitions:
  - `BEATS = ROWS*COLS/LANES`.
  - Stream index `k = beat*LANES + lane`.
  - Mapping for `k < COLS*SUB_ROWS`: `col = k / SUB_ROWS`, `row = k % SUB_ROWS`.
  - Otherwise, with `k' = k - COLS*SUB_ROWS` and `R2 = ROWS - SUB_ROWS`: `col = k' / R2`, `row = SUB_ROWS + k' % R2`.
- The mapping is static. Each array register has a fixed (beat, lane) source, and the write enable is `accept && beat_cnt == k/LANES`.
- State machine, two states:
  - FILL: `in_ready = 1`, `out_valid = 0`. Each accepted beat writes its `LANES` elements and increments `beat_cnt`. Accepting beat `BEATS-1` moves to HOLD and clears `beat_cnt` to 0.
  - HOLD: `in_ready = 0`, `out_valid = 1`. `out` is frozen. On `out_ready`, move to FILL.
- `beat_cnt` width is `$clog2(BEATS)`, minimum 1. It never exceeds `BEATS-1`.
- Array registers are not cleared between frames. During FILL, `out` shows a mix of old and new elements, and consumers must qualify with `out_valid`.
- Case `SUB_ROWS == ROWS`: the second region is empty, and the whole frame is column-major.

## Timing
- Reset values:
  - State = FILL, so `in_ready = 1` in the first cycle after reset.
  - `out_valid = 0`, `beat_cnt = 0`.
  - All `out` elements = 0.
- `in_ready` and `out_valid` are decoded directly from the state register, with no combinational path from the inputs.
- Latency: `out_valid` rises in the cycle after the last beat is accepted.
- The frame handshake takes one cycle. After `out_valid && out_ready`, `in_ready` is high the next cycle. This gives one bubble per frame, and minimum throughput is `BEATS+1` cycles per frame.
- `in_valid` low during FILL: no write, and `beat_cnt` holds. Gaps of any length are allowed.
- `rst` mid-frame: all partial data is discarded, and the outputs return to their reset values next cycle.
- `out_ready` held high in FILL has no effect.

## Configuration
- `SUB_ARRAY_LOADER_FLUSH_EN` defined: the `flush` port exists.
  - `flush` high forces `in_ready = 0` combinationally that cycle, so no beat is accepted.
  - Next cycle: state = FILL, `beat_cnt = 0`, `out_valid = 0`. Array contents are retained.
  - `flush` has priority over `out_ready` in HOLD. The frame is dropped without a handshake.
- Macro not defined: no `flush` port, and `in_ready` depends only on state.

## Test plan
All scenarios use the defaults, so `BEATS = 32`.

1. Reset, then stream `k mod 16` for `k = 0..63` with `in_valid` always high and `out_ready` low.
   - `out_valid` rises 1 cycle after beat 31.
   - `out[0][0]=0`, `out[3][0]=3`, `out[0][1]=4`, `out[4][0]=0`, `out[5][0]=1`, `out[7][7]=15`.
   - `in_ready = 0` while waiting.
2. Same stream with `in_valid` toggling every other cycle.
   - Identical `out` contents.
   - `out_valid` rises 1 cycle after the 32nd accepted beat.
3. Hold `out_ready` low for 10 cycles after `out_valid`, then pulse it.
   - `out` is unchanged for all 10 cycles.
   - `in_ready = 1` on the cycle after the pulse.
   - A second frame of all `0xA` gives every element `= 0xA`.
4. Assert `rst` after 12 beats.
   - Next cycle: all `out` elements = 0, `out_valid = 0`.
   - A full new frame then loads correctly from beat 0.
5. With `SUB_ARRAY_LOADER_FLUSH_EN`, assert `flush` with `in_valid` high after beat 20.
   - That beat is not accepted.
   - The next 32 beats complete a frame, and `out_valid` rises exactly after them.
   - `flush` in HOLD drops `out_valid` without a handshake.
6. `SUB_ROWS = ROWS = 8`, stream `k mod 16`: `out[1][0]=1`, `out[0][1]=8`, `out[7][7]=15`.
